ctrl_tx_serializer: RTL and testbench
=====================================

// Module: ctrl_tx_serializer
// PURPOSE
//  Parametrised system-controller TX path: takes ALU results (ALU_W bits) and register-read data (RD_W bits),
//  buffers one pending word per source at its valid strobe, serialises each word into DATA_W-bit bytes,
//  and hands them to the UART TX using the TX_D_VLD / Busy handshake.
//  Successor to the fixed 16-bit ALU / 8-bit read TX controller. Adds width generality, selectable byte order,
//  selectable arbitration, capture at the valid strobe, and overflow reporting.
// PARAMETERS
//  DATA_W     8   UART frame payload width
//  ALU_W      16  ALU result width; must be a multiple of DATA_W
//  RD_W       8   register-read data width; must be a multiple of DATA_W
//  LSB_FIRST  1   1: least-significant byte sent first; 0: most-significant first
//  ARB_RR     0   0: fixed priority, RdData wins; 1: round-robin between sources
// PORTS
//  CLK          in   1       system clock
//  RST          in   1       asynchronous, active-high reset
//  ALU_OUT      in   ALU_W   ALU result, sampled when ALU_OUT_VLD=1
//  ALU_OUT_VLD  in   1       ALU result strobe
//  RdData       in   RD_W    register-file read data, sampled when RdData_VLD=1
//  RdData_VLD   in   1       read-data strobe
//  Busy         in   1       UART TX busy
//  TX_P_Data    out  DATA_W  byte presented to the UART TX
//  TX_D_VLD     out  1       byte valid; held until Busy is seen high
//  CLK_div_en   out  1       UART clock-divider enable
//  Ovf_Err      out  1       1-cycle pulse: a strobe was dropped because its slot was full
//  Tx_Idle      out  1       1 when FSM is IDLE and no slot is pending
// BEHAVIOUR
//  Reset (async, RST=1)
//   - TX_P_Data=0, TX_D_VLD=0, Ovf_Err=0, CLK_div_en=0, Tx_Idle=1.
//   - State=IDLE, both slots empty, byte counter=0, round-robin pointer points to RdData.
//   - Reset mid-transfer: the word is abandoned and TX_D_VLD drops immediately.
//  Capture
//   - On a valid strobe the word is stored in its slot at that clock edge.
//   - Strobe while the slot is full and not being consumed on the same edge: new word is dropped,
//     old word is kept, Ovf_Err pulses on the next cycle.
//   - Strobe on the same edge the slot is consumed: new word is stored, no error.
//  FSM states: IDLE, SEND, WAIT
//   - IDLE -> SEND when any slot is pending and Busy=0.
//     Arbitration picks the source; its word is loaded into the shift register; counter = NBYTES-1.
//   - SEND: TX_D_VLD=1. Busy=1 -> WAIT. Otherwise stay in SEND with data stable.
//   - WAIT: TX_D_VLD=0, TX_P_Data held. Busy=0 ->
//       counter!=0: shift by DATA_W toward the next byte, decrement counter, go to SEND;
//       else a slot is pending: arbitrate and load, go to SEND (back-to-back, IDLE not visited);
//       else go to IDLE.
//  Outputs and timing
//   - TX_P_Data = active byte of the shift register (registered).
//   - TX_D_VLD is decoded from the state register.
//   - Latency: strobe sampled at edge k -> TX_D_VLD=1 after edge k+1 (2 cycles), when idle and Busy=0.
//  Arbitration
//   - ARB_RR=0: RdData always wins.
//   - ARB_RR=1: the pointer toggles to the other source after each grant; a single requester is always granted.
//   - Simultaneous strobes in IDLE: both are captured and sent in arbitration order, with no loss.
//  Widths and enables
//   - NBYTES = W/DATA_W per source; counter width = clog2(max NBYTES), minimum 1.
//   - NBYTES=1: WAIT goes straight to the pending/IDLE decision.
//   - CLK_div_en = 1 whenever state!=IDLE or any slot is pending; registered, 0 in reset.
// STRUCTURE
//  - Package ctrl_tx_pkg: state encoding (IDLE/SEND/WAIT), source enum (SRC_RD/SRC_ALU), NBYTES function.
//  - Sub-module ctrl_tx_slot: one-entry holding register (valid, data, take, ovf), instantiated per source.
//  - Top holds the arbiter, shift register, byte counter and FSM.
// TESTING
//  1. ALU_W=16, LSB_FIRST=1: ALU_OUT=16'hA55A strobe, Busy model 10 cycles/byte.
//     -> TX bytes 5A then A5, one TX_D_VLD assertion per byte.
//  2. LSB_FIRST=0, ALU_W=32: ALU_OUT=32'h11223344.
//     -> TX bytes 11,22,33,44 in order; Tx_Idle=1 after the last Busy fall.
//  3. ARB_RR=0: RdData=8'h3C and ALU_OUT=16'hBEEF strobed in the same cycle.
//     -> 3C, EF, BE; Ovf_Err stays 0.
//  4. ARB_RR=1: alternate strobes of both sources, 4 words each.
//     -> sources granted alternately; no starvation.
//  5. Second ALU_OUT_VLD (16'h0001) while the first (16'h1234) is sending and the slot is already full again.
//     -> Ovf_Err pulses 1 cycle; the dropped word is never transmitted.
//  6. RST=1 for 1 cycle while in SEND on byte 2 of 2.
//     -> TX_D_VLD=0 at once, all outputs at reset values.
//     -> after release, a fresh strobe transmits normally.

Source files
------------

// File: rtl/ctrl_tx_pkg.sv
// Shared types for the controller TX serializer: FSM states, source ids and
// the per-source byte-count helper.
package ctrl_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    SRC_RD  = 1'b0,
    SRC_ALU = 1'b1
  } src_t;

  function automatic int unsigned nbytes(input int unsigned width, input int unsigned data_w);
    return width / data_w;
  endfunction

endpackage

// File: rtl/ctrl_tx_slot.sv
// One-entry holding register for a TX source. A strobe into a full slot that is
// not being drained on the same edge is dropped and flagged one cycle later.
module ctrl_tx_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data,
  input  logic         strobe,
  input  logic         take,
  output logic         valid,
  output logic [W-1:0] word,
  output logic         ovf
);

  logic store;

  // Draining and refilling on the same edge is legal; the new word replaces the old.
  assign store = strobe && (!valid || take);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= '0;
      ovf   <= 1'b0;
    end else begin
      ovf <= strobe && valid && !take;
      if (store) begin
        word  <= data;
        valid <= 1'b1;
      end else if (take) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ctrl_tx_serializer.sv
// System-controller TX path: buffers ALU and register-read words, arbitrates
// between them and serialises each word into DATA_W-bit bytes for the UART TX.
module ctrl_tx_serializer
  import ctrl_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ALU_W     = 16,
  parameter int unsigned RD_W      = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          ARB_RR    = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              ALU_OUT_VLD,
  input  logic [RD_W-1:0]   RdData,
  input  logic              RdData_VLD,
  input  logic              Busy,
  output logic [DATA_W-1:0] TX_P_Data,
  output logic              TX_D_VLD,
  output logic              CLK_div_en,
  output logic              Ovf_Err,
  output logic              Tx_Idle
);

  localparam int unsigned N_ALU = nbytes(ALU_W, DATA_W);
  localparam int unsigned N_RD  = nbytes(RD_W, DATA_W);
  localparam int unsigned N_MAX = (N_ALU > N_RD) ? N_ALU : N_RD;
  localparam int unsigned CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int unsigned SH_W  = N_MAX * DATA_W;

  state_t              state;
  src_t                rr_ptr;
  src_t                grant;
  logic [SH_W-1:0]     shreg;
  logic [SH_W-1:0]     load_word;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    load_cnt;
  logic                clk_div_en_q;
  logic                rd_valid, alu_valid;
  logic [RD_W-1:0]     rd_word;
  logic [ALU_W-1:0]    alu_word;
  logic                rd_ovf, alu_ovf;
  logic                rd_take, alu_take;
  logic                any_pend, load;

  ctrl_tx_slot #(.W(RD_W)) u_rd_slot (
    .clk    (CLK),
    .rst    (RST),
    .data   (RdData),
    .strobe (RdData_VLD),
    .take   (rd_take),
    .valid  (rd_valid),
    .word   (rd_word),
    .ovf    (rd_ovf)
  );

  ctrl_tx_slot #(.W(ALU_W)) u_alu_slot (
    .clk    (CLK),
    .rst    (RST),
    .data   (ALU_OUT),
    .strobe (ALU_OUT_VLD),
    .take   (alu_take),
    .valid  (alu_valid),
    .word   (alu_word),
    .ovf    (alu_ovf)
  );

  always_comb begin
    any_pend = rd_valid || alu_valid;
    if (ARB_RR && rd_valid && alu_valid) grant = rr_ptr;
    else if (rd_valid)                   grant = SRC_RD;
    else                                 grant = SRC_ALU;

    load = !Busy && any_pend && ((state == IDLE) || ((state == WAIT) && (cnt == '0)));
    rd_take  = load && (grant == SRC_RD);
    alu_take = load && (grant == SRC_ALU);

    // MSB-first words are left-aligned so the first byte always sits at the top.
    if (grant == SRC_RD) begin
      load_word = LSB_FIRST ? SH_W'(rd_word) : (SH_W'(rd_word) << (SH_W - RD_W));
      load_cnt  = CNT_W'(N_RD - 1);
    end else begin
      load_word = LSB_FIRST ? SH_W'(alu_word) : (SH_W'(alu_word) << (SH_W - ALU_W));
      load_cnt  = CNT_W'(N_ALU - 1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      shreg        <= '0;
      cnt          <= '0;
      rr_ptr       <= SRC_RD;
      clk_div_en_q <= 1'b0;
    end else begin
      clk_div_en_q <= (state != IDLE) || any_pend;
      if (load) begin
        shreg  <= load_word;
        cnt    <= load_cnt;
        rr_ptr <= (grant == SRC_RD) ? SRC_ALU : SRC_RD;
        state  <= SEND;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          SEND: if (Busy) state <= WAIT;
          WAIT: begin
            if (!Busy) begin
              if (cnt != '0) begin
                shreg <= LSB_FIRST ? (shreg >> DATA_W) : (shreg << DATA_W);
                cnt   <= cnt - 1'b1;
                state <= SEND;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign TX_P_Data  = LSB_FIRST ? shreg[DATA_W-1:0] : shreg[SH_W-1 -: DATA_W];
  assign TX_D_VLD   = (state == SEND);
  assign CLK_div_en = clk_div_en_q;
  assign Ovf_Err    = rd_ovf || alu_ovf;
  assign Tx_Idle    = (state == IDLE) && !any_pend;

endmodule

// File: tb/tb_ctrl_tx_serializer.sv
// Bench for ctrl_tx_serializer: two configurations (16-bit LSB-first fixed priority,
// 32-bit MSB-first round-robin) driven against a UART busy model and a byte-list model.
module tb_ctrl_tx_serializer;

  localparam int ACK_DLY  = 2;
  localparam int BYTE_CYC = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] alu0 = '0;
  logic        alu_vld0 = 1'b0;
  logic [7:0]  rd0 = '0;
  logic        rd_vld0 = 1'b0;
  logic [31:0] alu1 = '0;
  logic        alu_vld1 = 1'b0;
  logic [15:0] rd1 = '0;
  logic        rd_vld1 = 1'b0;

  logic       busy [2];
  logic       vld  [2];
  logic [7:0] txd  [2];
  logic       cde  [2];
  logic       ovf  [2];
  logic       idle [2];

  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  logic [7:0] exp_q [$];

  int         hold [2];
  int         bcnt [2];
  int         ovf_cnt [2];
  logic       pv [2];
  logic [7:0] held [2];
  int         stab_bad = 0;

  int vectors = 0;
  int miscompares = 0;

  ctrl_tx_serializer #(.DATA_W(8), .ALU_W(16), .RD_W(8), .LSB_FIRST(1'b1), .ARB_RR(1'b0)) dut0 (
    .CLK(clk), .RST(rst), .ALU_OUT(alu0), .ALU_OUT_VLD(alu_vld0), .RdData(rd0), .RdData_VLD(rd_vld0),
    .Busy(busy[0]), .TX_P_Data(txd[0]), .TX_D_VLD(vld[0]), .CLK_div_en(cde[0]), .Ovf_Err(ovf[0]),
    .Tx_Idle(idle[0])
  );

  ctrl_tx_serializer #(.DATA_W(8), .ALU_W(32), .RD_W(16), .LSB_FIRST(1'b0), .ARB_RR(1'b1)) dut1 (
    .CLK(clk), .RST(rst), .ALU_OUT(alu1), .ALU_OUT_VLD(alu_vld1), .RdData(rd1), .RdData_VLD(rd_vld1),
    .Busy(busy[1]), .TX_P_Data(txd[1]), .TX_D_VLD(vld[1]), .CLK_div_en(cde[1]), .Ovf_Err(ovf[1]),
    .Tx_Idle(idle[1])
  );

  // UART model: acknowledge a valid byte after ACK_DLY cycles, stay busy BYTE_CYC cycles.
  initial begin
    for (int i = 0; i < 2; i++) begin
      busy[i] = 1'b0; hold[i] = 0; bcnt[i] = 0; pv[i] = 1'b0; held[i] = '0; ovf_cnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          busy[i] = 1'b0; hold[i] = 0; bcnt[i] = 0; pv[i] = 1'b0;
        end else begin
          if (ovf[i]) ovf_cnt[i]++;
          if (vld[i] && !pv[i]) begin
            if (i == 0) got0.push_back(txd[i]);
            else        got1.push_back(txd[i]);
            held[i] = txd[i];
          end else if (vld[i] && (txd[i] !== held[i])) begin
            stab_bad++;
          end
          pv[i] = vld[i];
          if (bcnt[i] > 0) begin
            bcnt[i]--;
            if (bcnt[i] == 0) busy[i] = 1'b0;
          end else if (vld[i]) begin
            hold[i]++;
            if (hold[i] >= ACK_DLY) begin
              busy[i] = 1'b1; bcnt[i] = BYTE_CYC; hold[i] = 0;
            end
          end
        end
      end
    end
  end

  function automatic void push_word(input logic [31:0] w, input int nb, input bit lsb);
    for (int k = 0; k < nb; k++) begin
      int idx;
      idx = lsb ? k : nb - 1 - k;
      exp_q.push_back(w[8*idx +: 8]);
    end
  endfunction

  function automatic int got_size(input int i);
    return (i == 0) ? got0.size() : got1.size();
  endfunction

  function automatic logic [7:0] got_at(input int i, input int k);
    if (i == 0) return (k < got0.size()) ? got0[k] : 8'h00;
    return (k < got1.size()) ? got1[k] : 8'h00;
  endfunction

  function automatic void clear_all();
    got0.delete(); got1.delete(); exp_q.delete();
  endfunction

  task automatic strobe(input int i, input bit do_rd, input bit do_alu, input logic [31:0] aw,
                        input logic [15:0] rw);
    if (i == 0) begin alu0 = aw[15:0]; alu_vld0 = do_alu; rd0 = rw[7:0]; rd_vld0 = do_rd; end
    else        begin alu1 = aw;       alu_vld1 = do_alu; rd1 = rw;      rd_vld1 = do_rd; end
    @(negedge clk); #1;
    alu_vld0 = 1'b0; rd_vld0 = 1'b0; alu_vld1 = 1'b0; rd_vld1 = 1'b0;
  endtask

  task automatic wait_idle(input int i, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (idle[i] && !busy[i]) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++; if (txd[i] !== 8'h00) begin miscompares++; $display("FAIL reset_data%0d: got %h expected 00", i, txd[i]); end
      vectors++; if (vld[i] !== 1'b0) begin miscompares++; $display("FAIL reset_vld%0d: got %b expected 0", i, vld[i]); end
      vectors++; if (ovf[i] !== 1'b0) begin miscompares++; $display("FAIL reset_ovf%0d: got %b expected 0", i, ovf[i]); end
      vectors++; if (cde[i] !== 1'b0) begin miscompares++; $display("FAIL reset_cde%0d: got %b expected 0", i, cde[i]); end
      vectors++; if (idle[i] !== 1'b1) begin miscompares++; $display("FAIL reset_idle%0d: got %b expected 1", i, idle[i]); end
    end
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_lsb_first();
    bit ok;
    int sb;
    clear_all();
    sb = stab_bad;
    push_word(32'h0000A55A, 2, 1'b1);
    strobe(0, 1'b0, 1'b1, 32'h0000A55A, 16'h0);
    vectors++; if (vld[0] !== 1'b0) begin miscompares++; $display("FAIL lat_early: vld %b expected 0", vld[0]); end
    @(negedge clk); #1;
    vectors++; if (vld[0] !== 1'b1) begin miscompares++; $display("FAIL lat_vld: vld %b expected 1", vld[0]); end
    vectors++; if (txd[0] !== 8'h5A) begin miscompares++; $display("FAIL lat_data: got %h expected 5a", txd[0]); end
    vectors++; if (cde[0] !== 1'b1) begin miscompares++; $display("FAIL lat_cde: got %b expected 1", cde[0]); end
    wait_idle(0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL lsb_idle: got timeout expected idle"); end
    vectors++; if (got_size(0) != exp_q.size()) begin miscompares++; $display("FAIL lsb_count: got %0d expected %0d", got_size(0), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(0, k) !== exp_q[k]) begin miscompares++; $display("FAIL lsb_byte%0d: got %h expected %h", k, got_at(0, k), exp_q[k]); end
    end
    vectors++; if (stab_bad != sb) begin miscompares++; $display("FAIL lsb_stable: got %0d changes expected 0", stab_bad - sb); end
  endtask

  task automatic test_msb_first();
    bit ok;
    clear_all();
    push_word(32'h11223344, 4, 1'b0);
    strobe(1, 1'b0, 1'b1, 32'h11223344, 16'h0);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      if (got1.size() == 4 && busy[1]) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    for (int t = 0; t < 50 && busy[1]; t++) begin @(negedge clk); #1; end
    vectors++; if (!ok || busy[1]) begin miscompares++; $display("FAIL msb_last_byte: got timeout expected busy fall"); end
    vectors++; if (idle[1] !== 1'b0) begin miscompares++; $display("FAIL msb_idle_early: got %b expected 0", idle[1]); end
    @(negedge clk); #1;
    vectors++; if (idle[1] !== 1'b1) begin miscompares++; $display("FAIL msb_idle: got %b expected 1", idle[1]); end
    @(negedge clk); #1;
    vectors++; if (cde[1] !== 1'b0) begin miscompares++; $display("FAIL msb_cde_off: got %b expected 0", cde[1]); end
    vectors++; if (got_size(1) != exp_q.size()) begin miscompares++; $display("FAIL msb_count: got %0d expected %0d", got_size(1), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(1, k) !== exp_q[k]) begin miscompares++; $display("FAIL msb_byte%0d: got %h expected %h", k, got_at(1, k), exp_q[k]); end
    end
  endtask

  task automatic test_fixed_prio();
    bit ok;
    int o0;
    clear_all();
    o0 = ovf_cnt[0];
    push_word(32'h0000003C, 1, 1'b1);
    push_word(32'h0000BEEF, 2, 1'b1);
    strobe(0, 1'b1, 1'b1, 32'h0000BEEF, 16'h003C);
    wait_idle(0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL prio_idle: got timeout expected idle"); end
    vectors++; if (got_size(0) != exp_q.size()) begin miscompares++; $display("FAIL prio_count: got %0d expected %0d", got_size(0), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(0, k) !== exp_q[k]) begin miscompares++; $display("FAIL prio_byte%0d: got %h expected %h", k, got_at(0, k), exp_q[k]); end
    end
    vectors++; if (ovf_cnt[0] != o0) begin miscompares++; $display("FAIL prio_ovf: got %0d pulses expected 0", ovf_cnt[0] - o0); end
  endtask

  task automatic test_round_robin();
    logic [15:0] rw [4];
    logic [31:0] aw [4];
    int start, ri, ai, o0;
    bit ok;
    clear_all();
    o0 = ovf_cnt[1];
    for (int k = 0; k < 4; k++) begin rw[k] = 16'($urandom); aw[k] = $urandom; end
    for (int k = 0; k < 4; k++) begin push_word({16'h0, rw[k]}, 2, 1'b0); push_word(aw[k], 4, 1'b0); end
    strobe(1, 1'b1, 1'b1, aw[0], rw[0]);
    start = 0; ri = 1; ai = 1;
    for (int g = 0; g < 8; g++) begin
      ok = 1'b0;
      for (int t = 0; t < 500; t++) begin
        if (got1.size() > start) begin ok = 1'b1; break; end
        @(negedge clk); #1;
      end
      vectors++; if (!ok) begin miscompares++; $display("FAIL rr_grant%0d: got timeout expected word start", g); end
      if (g % 2 == 0) begin
        if (ri < 4) begin strobe(1, 1'b1, 1'b0, 32'h0, rw[ri]); ri++; end
        start += 2;
      end else begin
        if (ai < 4) begin strobe(1, 1'b0, 1'b1, aw[ai], 16'h0); ai++; end
        start += 4;
      end
    end
    wait_idle(1, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rr_idle: got timeout expected idle"); end
    vectors++; if (got_size(1) != exp_q.size()) begin miscompares++; $display("FAIL rr_count: got %0d expected %0d", got_size(1), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(1, k) !== exp_q[k]) begin miscompares++; $display("FAIL rr_byte%0d: got %h expected %h", k, got_at(1, k), exp_q[k]); end
    end
    vectors++; if (ovf_cnt[1] != o0) begin miscompares++; $display("FAIL rr_ovf: got %0d pulses expected 0", ovf_cnt[1] - o0); end
  endtask

  task automatic test_overflow();
    bit ok;
    int o0;
    clear_all();
    o0 = ovf_cnt[0];
    push_word(32'h00001234, 2, 1'b1);
    push_word(32'h00005678, 2, 1'b1);
    strobe(0, 1'b0, 1'b1, 32'h00001234, 16'h0);
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (got0.size() >= 1) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_start: got timeout expected first byte"); end
    strobe(0, 1'b0, 1'b1, 32'h00005678, 16'h0);
    vectors++; if (ovf[0] !== 1'b0) begin miscompares++; $display("FAIL ovf_refill: got %b expected 0", ovf[0]); end
    strobe(0, 1'b0, 1'b1, 32'h00000001, 16'h0);
    vectors++; if (ovf[0] !== 1'b1) begin miscompares++; $display("FAIL ovf_pulse: got %b expected 1", ovf[0]); end
    @(negedge clk); #1;
    vectors++; if (ovf[0] !== 1'b0) begin miscompares++; $display("FAIL ovf_width: got %b expected 0", ovf[0]); end
    wait_idle(0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ovf_idle: got timeout expected idle"); end
    vectors++; if (got_size(0) != exp_q.size()) begin miscompares++; $display("FAIL ovf_count: got %0d expected %0d", got_size(0), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(0, k) !== exp_q[k]) begin miscompares++; $display("FAIL ovf_byte%0d: got %h expected %h", k, got_at(0, k), exp_q[k]); end
    end
    vectors++; if (ovf_cnt[0] - o0 != 1) begin miscompares++; $display("FAIL ovf_total: got %0d pulses expected 1", ovf_cnt[0] - o0); end
  endtask

  task automatic test_same_edge();
    bit ok;
    int o0;
    clear_all();
    o0 = ovf_cnt[0];
    push_word(32'h00009A7C, 2, 1'b1);
    push_word(32'h000042E1, 2, 1'b1);
    alu0 = 16'h9A7C; alu_vld0 = 1'b1;
    @(negedge clk); #1;
    alu0 = 16'h42E1;
    @(negedge clk); #1;
    alu_vld0 = 1'b0;
    vectors++; if (ovf[0] !== 1'b0) begin miscompares++; $display("FAIL same_edge_ovf: got %b expected 0", ovf[0]); end
    wait_idle(0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL same_edge_idle: got timeout expected idle"); end
    vectors++; if (got_size(0) != exp_q.size()) begin miscompares++; $display("FAIL same_edge_count: got %0d expected %0d", got_size(0), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(0, k) !== exp_q[k]) begin miscompares++; $display("FAIL same_edge_byte%0d: got %h expected %h", k, got_at(0, k), exp_q[k]); end
    end
    vectors++; if (ovf_cnt[0] != o0) begin miscompares++; $display("FAIL same_edge_total: got %0d pulses expected 0", ovf_cnt[0] - o0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_all();
    push_word(32'h0000C0DE, 2, 1'b1);
    push_word(32'h00000BAD, 2, 1'b1);
    strobe(0, 1'b0, 1'b1, 32'h0000C0DE, 16'h0);
    ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      if (got0.size() == 2 && vld[0] && !busy[0]) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_reach: got timeout expected byte 2 in SEND"); end
    rst = 1'b1;
    #1;
    vectors++; if (vld[0] !== 1'b0) begin miscompares++; $display("FAIL rstmid_vld: got %b expected 0", vld[0]); end
    vectors++; if (txd[0] !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h expected 00", txd[0]); end
    vectors++; if (cde[0] !== 1'b0) begin miscompares++; $display("FAIL rstmid_cde: got %b expected 0", cde[0]); end
    vectors++; if (idle[0] !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle: got %b expected 1", idle[0]); end
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    strobe(0, 1'b0, 1'b1, 32'h00000BAD, 16'h0);
    wait_idle(0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rstmid_idle_after: got timeout expected idle"); end
    vectors++; if (got_size(0) != exp_q.size()) begin miscompares++; $display("FAIL rstmid_count: got %0d expected %0d", got_size(0), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(0, k) !== exp_q[k]) begin miscompares++; $display("FAIL rstmid_byte%0d: got %h expected %h", k, got_at(0, k), exp_q[k]); end
    end
  endtask

  // Expects the round-robin pointer at its reset value (RdData) on entry.
  task automatic test_random(input int i);
    bit ok, ptr_rd, do_rd, do_alu, lsb;
    int kind, nr, na, o0, sb;
    logic [31:0] aw;
    logic [15:0] rw;
    clear_all();
    o0 = ovf_cnt[i];
    sb = stab_bad;
    ptr_rd = 1'b1;
    nr = (i == 0) ? 1 : 2;
    na = (i == 0) ? 2 : 4;
    lsb = (i == 0);
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 2);
      aw = $urandom;
      rw = 16'($urandom);
      do_rd = (kind != 1);
      do_alu = (kind != 0);
      if (do_rd && do_alu) begin
        if (i == 0 || ptr_rd) begin push_word({16'h0, rw}, nr, lsb); push_word(aw, na, lsb); end
        else begin push_word(aw, na, lsb); push_word({16'h0, rw}, nr, lsb); end
      end else if (do_rd) begin
        push_word({16'h0, rw}, nr, lsb); ptr_rd = 1'b0;
      end else begin
        push_word(aw, na, lsb); ptr_rd = 1'b1;
      end
      strobe(i, do_rd, do_alu, aw, rw);
      wait_idle(i, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rand%0d_idle%0d: got timeout expected idle", i, n); end
      repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
    end
    vectors++; if (got_size(i) != exp_q.size()) begin miscompares++; $display("FAIL rand%0d_count: got %0d expected %0d", i, got_size(i), exp_q.size()); end
    foreach (exp_q[k]) begin
      vectors++; if (got_at(i, k) !== exp_q[k]) begin miscompares++; $display("FAIL rand%0d_byte%0d: got %h expected %h", i, k, got_at(i, k), exp_q[k]); end
    end
    vectors++; if (ovf_cnt[i] != o0) begin miscompares++; $display("FAIL rand%0d_ovf: got %0d pulses expected 0", i, ovf_cnt[i] - o0); end
    vectors++; if (stab_bad != sb) begin miscompares++; $display("FAIL rand%0d_stable: got %0d changes expected 0", i, stab_bad - sb); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_fixed_prio();
    test_round_robin();
    test_overflow();
    test_same_edge();
    test_reset_mid();
    test_random(0);
    test_random(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
